iis_tx_fifo_sched: RTL and testbench

Read-side scheduler for the I2S transmit path. It runs in the read clock domain of two per-channel async FIFOs (left, right), with data width DW. On each frame request from the I2S serializer it reads one left and one right sample, then presents them as a registered pair. It also handles mono duplication, underrun muting and underrun statistics.

---
 rtl/iis_tx_fifo_sched.sv | 155 +++++++++++++++
 tb/tb_iis_tx_fifo_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iis_tx_fifo_sched.sv
// I2S transmit read-side scheduler: pulls one L/R pair per frame request
// from two per-channel FIFOs, with mono duplication and underrun handling.
module iis_tx_fifo_sched #(
  parameter int DW               = 16,
  parameter int CNT_W            = 16,
  parameter int HOLD_ON_UNDERRUN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mono,
  input  logic             sample_req,
  input  logic             l_empty,
  input  logic             l_vaild,
  input  logic [DW-1:0]    l_dout,
  input  logic             r_empty,
  input  logic             r_vaild,
  input  logic [DW-1:0]    r_dout,
  output logic             l_rd_en,
  output logic             r_rd_en,
  output logic [DW-1:0]    smp_left,
  output logic [DW-1:0]    smp_right,
  output logic             smp_valid,
  output logic             busy,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic             req_miss,
  input  logic             clr_stat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L_ISSUE,
    S_L_CAPT,
    S_R_ISSUE,
    S_R_CAPT
  } state_t;

  state_t           r_state, w_state;
  logic             r_mono, w_mono;
  logic             r_l_rd_en, w_l_rd_en;
  logic             r_r_rd_en, w_r_rd_en;
  logic [DW-1:0]    r_cap_l, w_cap_l;
  logic [DW-1:0]    r_last_l, w_last_l;
  logic [DW-1:0]    r_last_r, w_last_r;
  logic [DW-1:0]    r_smp_l, w_smp_l;
  logic [DW-1:0]    r_smp_r, w_smp_r;
  logic             r_smp_vld, w_smp_vld;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_miss, w_miss;
  logic             w_inc;
  logic             w_miss_evt;
  logic [DW-1:0]    w_left;
  logic [DW-1:0]    w_right;

  always_comb begin
    w_state    = r_state;
    w_mono     = r_mono;
    w_l_rd_en  = 1'b0;
    w_r_rd_en  = 1'b0;
    w_cap_l    = r_cap_l;
    w_last_l   = r_last_l;
    w_last_r   = r_last_r;
    w_smp_l    = r_smp_l;
    w_smp_r    = r_smp_r;
    w_smp_vld  = 1'b0;
    w_inc      = 1'b0;
    w_miss_evt = sample_req && ((r_state != S_IDLE) || !enable);
    // Underrun substitute: silence, or repeat the channel's last good sample
    w_left     = l_vaild ? l_dout :
                 ((HOLD_ON_UNDERRUN != 0) ? r_last_l : '0);
    w_right    = r_vaild ? r_dout :
                 ((HOLD_ON_UNDERRUN != 0) ? r_last_r : '0);
    unique case (r_state)
      S_IDLE: begin
        if (sample_req && enable) begin
          w_l_rd_en = !l_empty;
          w_inc     = l_empty;
          w_mono    = mono;
          w_state   = S_L_ISSUE;
        end
      end
      S_L_ISSUE: w_state = S_L_CAPT;
      S_L_CAPT: begin
        w_cap_l = w_left;
        if (l_vaild) w_last_l = l_dout;
        if (r_mono) begin
          w_smp_l   = w_left;
          w_smp_r   = w_left;
          w_smp_vld = 1'b1;
          w_state   = S_IDLE;
        end else begin
          w_r_rd_en = !r_empty;
          w_inc     = r_empty;
          w_state   = S_R_ISSUE;
        end
      end
      S_R_ISSUE: w_state = S_R_CAPT;
      S_R_CAPT: begin
        if (r_vaild) w_last_r = r_dout;
        w_smp_l   = r_cap_l;
        w_smp_r   = w_right;
        w_smp_vld = 1'b1;
        w_state   = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    if (clr_stat) begin
      w_cnt  = '0;
      w_miss = 1'b0;
    end else begin
      w_cnt  = (w_inc && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;
      w_miss = r_miss | w_miss_evt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_mono    <= 1'b0;
      r_l_rd_en <= 1'b0;
      r_r_rd_en <= 1'b0;
      r_cap_l   <= '0;
      r_last_l  <= '0;
      r_last_r  <= '0;
      r_smp_l   <= '0;
      r_smp_r   <= '0;
      r_smp_vld <= 1'b0;
      r_cnt     <= '0;
      r_miss    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_mono    <= w_mono;
      r_l_rd_en <= w_l_rd_en;
      r_r_rd_en <= w_r_rd_en;
      r_cap_l   <= w_cap_l;
      r_last_l  <= w_last_l;
      r_last_r  <= w_last_r;
      r_smp_l   <= w_smp_l;
      r_smp_r   <= w_smp_r;
      r_smp_vld <= w_smp_vld;
      r_cnt     <= w_cnt;
      r_miss    <= w_miss;
    end
  end

  assign l_rd_en      = r_l_rd_en;
  assign r_rd_en      = r_r_rd_en;
  assign smp_left     = r_smp_l;
  assign smp_right    = r_smp_r;
  assign smp_valid    = r_smp_vld;
  assign busy         = (r_state != S_IDLE);
  assign underrun_cnt = r_cnt;
  assign req_miss     = r_miss;

endmodule

// File: tb/tb_iis_tx_fifo_sched.sv
// Bench for iis_tx_fifo_sched: zero-substitute/wide-counter and
// hold/4-bit-counter builds driven in lockstep, checked against a pair model.
module tb_iis_tx_fifo_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        mono = 1'b0;
  logic        sample_req = 1'b0;
  logic        clr_stat = 1'b0;
  logic        l_empty, r_empty;
  logic        l_vaild = 1'b0;
  logic        r_vaild = 1'b0;
  logic [15:0] l_dout = '0;
  logic [15:0] r_dout = '0;

  logic        lrd_a, rrd_a, vld_a, busy_a, miss_a;
  logic [15:0] sl_a, sr_a, cnt_a;
  logic        lrd_b, rrd_b, vld_b, busy_b, miss_b;
  logic [15:0] sl_b, sr_b;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iis_tx_fifo_sched #(.DW(16), .CNT_W(16), .HOLD_ON_UNDERRUN(0)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .mono(mono),
    .sample_req(sample_req),
    .l_empty(l_empty), .l_vaild(l_vaild), .l_dout(l_dout),
    .r_empty(r_empty), .r_vaild(r_vaild), .r_dout(r_dout),
    .l_rd_en(lrd_a), .r_rd_en(rrd_a),
    .smp_left(sl_a), .smp_right(sr_a), .smp_valid(vld_a),
    .busy(busy_a), .underrun_cnt(cnt_a), .req_miss(miss_a),
    .clr_stat(clr_stat)
  );

  iis_tx_fifo_sched #(.DW(16), .CNT_W(4), .HOLD_ON_UNDERRUN(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .mono(mono),
    .sample_req(sample_req),
    .l_empty(l_empty), .l_vaild(l_vaild), .l_dout(l_dout),
    .r_empty(r_empty), .r_vaild(r_vaild), .r_dout(r_dout),
    .l_rd_en(lrd_b), .r_rd_en(rrd_b),
    .smp_left(sl_b), .smp_right(sr_b), .smp_valid(vld_b),
    .busy(busy_b), .underrun_cnt(cnt_b), .req_miss(miss_b),
    .clr_stat(clr_stat)
  );

  // FIFO models: one-cycle read latency, fed by dut_a's read enables
  logic [15:0] l_mem [64];
  logic [15:0] r_mem [64];
  int l_wr = 0, l_rd = 0, r_wr = 0, r_rd = 0;
  assign l_empty = (l_wr == l_rd);
  assign r_empty = (r_wr == r_rd);

  always @(posedge clk) begin
    l_vaild <= lrd_a;
    r_vaild <= rrd_a;
    if (lrd_a) begin
      l_dout <= l_mem[l_rd % 64];
      l_rd   <= l_rd + 1;
    end
    if (rrd_a) begin
      r_dout <= r_mem[r_rd % 64];
      r_rd   <= r_rd + 1;
    end
  end

  // Pair model: outcome decided at acceptance, shown lat edges later
  int          m_since = -1;
  int          m_lat = 4;
  bit          m_lnon, m_rnon, m_miss;
  logic [15:0] m_lastL [2];
  logic [15:0] m_lastR [2];
  logic [15:0] m_pL [2];
  logic [15:0] m_pR [2];
  logic [15:0] m_L [2];
  logic [15:0] m_R [2];
  int          m_cnt [2];
  int          m_max [2] = '{65535, 15};

  task automatic model_reset();
    m_since = -1; m_lat = 4;
    m_lnon = 0; m_rnon = 0; m_miss = 0;
    for (int d = 0; d < 2; d++) begin
      m_lastL[d] = '0; m_lastR[d] = '0;
      m_pL[d] = '0; m_pR[d] = '0;
      m_L[d] = '0; m_R[d] = '0;
      m_cnt[d] = 0;
    end
  endtask

  task automatic model_edge();
    bit          bn;
    logic [15:0] lv, rv;
    int          u;
    bn = (m_since >= 0) && (m_since < m_lat);
    if (clr_stat) m_miss = 1'b0;
    else if (sample_req && (bn || !enable)) m_miss = 1'b1;
    if (m_since >= 0 && m_since < 100) m_since++;
    if (sample_req && enable && !bn) begin
      m_since = 0;
      m_lat = mono ? 2 : 4;
      m_lnon = (l_wr != l_rd);
      m_rnon = !mono && (r_wr != r_rd);
      for (int d = 0; d < 2; d++) begin
        lv = m_lnon ? l_mem[l_rd % 64] : (d == 1 ? m_lastL[d] : 16'h0);
        if (m_lnon) m_lastL[d] = lv;
        if (mono) rv = lv;
        else begin
          rv = m_rnon ? r_mem[r_rd % 64] : (d == 1 ? m_lastR[d] : 16'h0);
          if (m_rnon) m_lastR[d] = rv;
        end
        m_pL[d] = lv;
        m_pR[d] = rv;
        u = (m_lnon ? 0 : 1) + ((!mono && !m_rnon) ? 1 : 0);
        m_cnt[d] = (m_cnt[d] + u > m_max[d]) ? m_max[d] : m_cnt[d] + u;
      end
    end
    if (clr_stat) begin
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end
    if (m_since == m_lat) begin
      for (int d = 0; d < 2; d++) begin
        m_L[d] = m_pL[d];
        m_R[d] = m_pR[d];
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_edge();
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input int d, input logic lrd, input logic rrd,
                     input logic bsy, input logic vld,
                     input logic [15:0] sl, input logic [15:0] sr,
                     input logic miss, input logic [15:0] cnt);
    bit eb;
    eb = (m_since >= 0) && (m_since < m_lat);
    chk($sformatf("d%0d_l_rd_en", d), lrd, m_since == 0 && m_lnon);
    chk($sformatf("d%0d_r_rd_en", d), rrd, m_since == 2 && m_rnon);
    chk($sformatf("d%0d_busy", d), bsy, eb);
    chk($sformatf("d%0d_smp_valid", d), vld, m_since == m_lat);
    chk($sformatf("d%0d_smp_left", d), sl, m_L[d]);
    chk($sformatf("d%0d_smp_right", d), sr, m_R[d]);
    chk($sformatf("d%0d_req_miss", d), miss, m_miss);
    if (!eb) chk($sformatf("d%0d_underrun_cnt", d), cnt, m_cnt[d]);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cmp(0, lrd_a, rrd_a, busy_a, vld_a, sl_a, sr_a, miss_a, cnt_a);
      cmp(1, lrd_b, rrd_b, busy_b, vld_b, sl_b, sr_b, miss_b, {12'h0, cnt_b});
    end
  end

  task automatic push_l(input logic [15:0] v);
    l_mem[l_wr % 64] = v;
    l_wr++;
  endtask

  task automatic push_r(input logic [15:0] v);
    r_mem[r_wr % 64] = v;
    r_wr++;
  endtask

  // Returns on the negedge just after the accepting edge
  task automatic req(input logic m);
    @(negedge clk);
    sample_req = 1'b1;
    mono = m;
    @(negedge clk);
    sample_req = 1'b0;
    mono = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
  endtask

  int vcount;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_valid", vld_a, 1'b0);
    chk("rst_cnt", cnt_a, 16'h0);
    #2 rst = 1'b1;
    enable = 1'b1;

    // Stereo pair
    push_l(16'h1234); push_r(16'hABCD);
    req(1'b0);
    chk("st_l_rd_en", lrd_a, 1'b1);
    repeat (2) @(negedge clk);
    chk("st_r_rd_en", rrd_a, 1'b1);
    repeat (2) @(negedge clk);
    chk("st_valid", vld_a, 1'b1);
    chk("st_left", sl_a, 16'h1234);
    chk("st_right", sr_a, 16'hABCD);
    chk("st_cnt", cnt_a, 16'h0);
    repeat (2) @(negedge clk);

    // Mono duplication
    push_l(16'h5A5A);
    req(1'b1);
    repeat (2) @(negedge clk);
    chk("mono_valid", vld_a, 1'b1);
    chk("mono_left", sl_a, 16'h5A5A);
    chk("mono_right", sr_a, 16'h5A5A);
    repeat (2) @(negedge clk);

    // Left underrun: zero vs hold of the prior good left
    push_l(16'h1111); push_r(16'h2222);
    req(1'b0);
    repeat (5) @(negedge clk);
    push_r(16'h0F0F);
    req(1'b0);
    chk("ur_no_l_rd_en", lrd_a, 1'b0);
    repeat (4) @(negedge clk);
    chk("ur_left_zero", sl_a, 16'h0000);
    chk("ur_left_hold", sl_b, 16'h1111);
    chk("ur_right", sr_a, 16'h0F0F);
    chk("ur_cnt", cnt_a, 16'h1);
    repeat (2) @(negedge clk);

    // Request while busy is dropped
    push_l(16'h0101); push_r(16'h0202);
    req(1'b0);
    req(1'b0);
    vcount = 0;
    repeat (6) begin
      @(negedge clk);
      vcount += int'(vld_a);
    end
    chk("miss_one_valid", vcount, 1);
    chk("miss_sticky", miss_a, 1'b1);
    clr();
    chk("clr_miss", miss_a, 1'b0);
    chk("clr_cnt", cnt_a, 16'h0);

    // Request while disabled is dropped
    enable = 1'b0;
    req(1'b0);
    repeat (2) @(negedge clk);
    chk("dis_miss", miss_a, 1'b1);
    chk("dis_busy", busy_a, 1'b0);
    enable = 1'b1;
    clr();

    // Disable mid-sequence: pair still completes
    push_l(16'h3333); push_r(16'h4444);
    req(1'b0);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("dis_mid_valid", vld_a, 1'b1);
    chk("dis_mid_right", sr_a, 16'h4444);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // Saturation with both FIFOs empty
    clr();
    repeat (16) begin
      req(1'b0);
      repeat (5) @(negedge clk);
    end
    chk("sat_cnt4", cnt_b, 4'hF);
    chk("sat_cnt16", cnt_a, 16'd32);

    // Reset while right read is being issued
    push_l(16'h7777); push_r(16'h8888);
    req(1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_r_rd_en", rrd_a, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_r_rd_en", rrd_a, 1'b0);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_left_b", sl_b, 16'h0);
    chk("mid_rst_cnt", cnt_a, 16'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    push_l(16'h9999); push_r(16'hAAAA);
    req(1'b0);
    repeat (4) @(negedge clk);
    chk("post_rst_valid", vld_a, 1'b1);
    chk("post_rst_left", sl_a, 16'h9999);
    chk("post_rst_right", sr_a, 16'h8888);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

endmodule
